// File: rtl/mem_responder.sv
// Memory-side bus responder: one load/store at a time against a word-wide synchronous RAM,
// with read-modify-write for byte/halfword stores and misalignment rejection.
module mem_responder #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [1:0]             lane_q;
    logic                   we_q;
    logic [1:0]             size_q;
    logic [31:0]            wdata_q;
    logic                   err_q;
    logic [31:0]            rd_q;

    logic [31:0]            mem [0:(1<<ADDR_BITS)-1];
    logic [31:0]            mem_rd;
    logic                   mem_we;
    logic [31:0]            mem_wdata;
    logic [31:0]            merged;
    logic [31:0]            load_fmt;
    logic                   misalign_c;
    logic                   word_store_q;

    // Bits above the word index are intentionally ignored so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_BITS+2];

    assign misalign_c   = (size == SZ_WORD && addr[1:0] != 2'b00)
                       || (size == SZ_HALF && addr[0])
                       || (size == 2'b11);
    assign word_store_q = we_q && (size_q == SZ_WORD);
    assign mem_rd       = mem[idx_q];

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = misalign_c ? RESP : ACCESS;
            ACCESS:  state_d = (we_q && !word_store_q) ? MERGE : RESP;
            MERGE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        merged = rd_q;
        if (size_q == SZ_BYTE)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (lane_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    always_comb begin
        case (size_q)
            SZ_WORD: load_fmt = mem_rd;
            SZ_HALF: load_fmt = {16'b0, lane_q[1] ? mem_rd[31:16] : mem_rd[15:0]};
            default: load_fmt = {24'b0, mem_rd[{lane_q, 3'b000} +: 8]};
        endcase
    end

    // Reset wins over any pending write, so an aborted MERGE never lands.
    assign mem_we    = reset_n && ((state_q == ACCESS && word_store_q) || state_q == MERGE);
    assign mem_wdata = (state_q == MERGE) ? merged : wdata_q;

    // NOTE: RAM contents are deliberately not reset; only the write is gated, which keeps
    // the array mappable onto a plain block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= mem_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            wdata_q <= 32'b0;
            err_q   <= 1'b0;
            rd_q    <= 32'b0;
            rdata   <= 32'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                idx_q   <= addr[ADDR_BITS+1:2];
                lane_q  <= addr[1:0];
                we_q    <= we;
                size_q  <= size;
                wdata_q <= wdata;
                err_q   <= misalign_c;
            end
            if (state_q == ACCESS && !word_store_q)
                rd_q <= mem_rd;
            // Load result is registered as the RAM word is read, so it is valid alongside done.
            if (state_q == ACCESS && !we_q)
                rdata <= load_fmt;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == RESP);
    assign misaligned = done && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table of requests with hand-computed
// latency/misaligned/rdata, plus hold-req and reset-in-MERGE sequences.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] rdata;
    logic        done;
    logic        misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    mem_responder #(.ADDR_BITS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .rdata      (rdata),
        .done       (done),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        mis;
        logic [31:0] rdata;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one request from IDLE, then verify latency, misaligned, the single-cycle
    // done pulse and rdata in the following idle cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        we = v.we; size = v.sz; addr = v.addr; wdata = v.wdata; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; we = ~v.we; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A; size = 2'b10;
        lat = 0;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency[%0d]", idx), lat, v.lat);
        check($sformatf("misaligned[%0d]", idx), {31'b0, misaligned}, {31'b0, v.mis});
        @(posedge clk); #1;
        check($sformatf("idle_after[%0d]", idx), {30'b0, done, busy}, 32'b0);
        check($sformatf("rdata[%0d]", idx), rdata, v.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones;
        vec_t v;

        //            we    sz     addr          wdata          lat mis rdata after
        vecs[0]  = '{1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b00, 32'h0000_0010, 32'h0000_0000, 1, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 2'b00, 32'h0000_0020, 32'h1122_3344, 1, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 2'b10, 32'h0000_0022, 32'h1234_56AA, 2, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 2'b00, 32'h0000_0020, 32'h0000_0000, 1, 1'b0, 32'h11AA_3344};
        vecs[5]  = '{1'b0, 2'b10, 32'h0000_0022, 32'h0000_0000, 1, 1'b0, 32'h0000_00AA};
        vecs[6]  = '{1'b1, 2'b00, 32'h0000_0030, 32'h0000_0000, 1, 1'b0, 32'h0000_00AA};
        vecs[7]  = '{1'b1, 2'b01, 32'h0000_0032, 32'hCAFE_BEEF, 2, 1'b0, 32'h0000_00AA};
        vecs[8]  = '{1'b0, 2'b00, 32'h0000_0030, 32'h0000_0000, 1, 1'b0, 32'hBEEF_0000};
        vecs[9]  = '{1'b0, 2'b01, 32'h0000_0030, 32'h0000_0000, 1, 1'b0, 32'h0000_0000};
        vecs[10] = '{1'b0, 2'b01, 32'h0000_0032, 32'h0000_0000, 1, 1'b0, 32'h0000_BEEF};
        vecs[11] = '{1'b1, 2'b00, 32'h0000_0040, 32'h5566_7788, 1, 1'b0, 32'h0000_BEEF};
        vecs[12] = '{1'b0, 2'b00, 32'h0000_0041, 32'h0000_0000, 0, 1'b1, 32'h0000_BEEF};
        vecs[13] = '{1'b1, 2'b01, 32'h0000_0043, 32'h0000_FFFF, 0, 1'b1, 32'h0000_BEEF};
        vecs[14] = '{1'b0, 2'b11, 32'h0000_0040, 32'h0000_0000, 0, 1'b1, 32'h0000_BEEF};
        vecs[15] = '{1'b1, 2'b11, 32'h0000_0040, 32'h0000_0000, 0, 1'b1, 32'h0000_BEEF};
        vecs[16] = '{1'b0, 2'b00, 32'h0000_0040, 32'h0000_0000, 1, 1'b0, 32'h5566_7788};
        vecs[17] = '{1'b0, 2'b10, 32'h0000_0043, 32'h0000_0000, 1, 1'b0, 32'h0000_0055};
        vecs[18] = '{1'b0, 2'b10, 32'h0000_0040, 32'h0000_0000, 1, 1'b0, 32'h0000_0088};
        vecs[19] = '{1'b1, 2'b00, 32'h0000_0400, 32'h0BAD_F00D, 1, 1'b0, 32'h0000_0088};
        vecs[20] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 1, 1'b0, 32'h0BAD_F00D};
        vecs[21] = '{1'b1, 2'b01, 32'h0000_0041, 32'h0000_1234, 0, 1'b1, 32'h0BAD_F00D};
        vecs[22] = '{1'b0, 2'b00, 32'h0000_0040, 32'h0000_0000, 1, 1'b0, 32'h5566_7788};
        vecs[23] = '{1'b1, 2'b10, 32'h0000_0043, 32'hFFFF_FF99, 2, 1'b0, 32'h5566_7788};
        vecs[24] = '{1'b0, 2'b00, 32'h0000_0040, 32'h0000_0000, 1, 1'b0, 32'h9966_7788};

        reset_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = 32'b0; wdata = 32'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {29'b0, busy, done, misaligned}, 32'b0);
        check("reset_rdata", rdata, 32'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // req held high across a whole load, with inputs changing after acceptance.
        we = 1'b0; size = 2'b00; addr = 32'h0000_0010; req = 1'b1;
        @(posedge clk); #1;
        addr = 32'h0000_0020; we = 1'b1; wdata = 32'h0; size = 2'b10;
        check("hold_busy", {31'b0, busy}, 32'd1);
        dones = 0;
        @(posedge clk); #1;
        if (done) dones++;
        @(posedge clk); #1;
        if (done) dones++;
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("hold_done_count", dones, 1);
        check("hold_rdata", rdata, 32'hDEAD_BEEF);
        v = '{1'b0, 2'b00, 32'h0000_0020, 32'h0, 1, 1'b0, 32'h11AA_3344};
        run_vec(v, 100);

        // Reset asserted during the MERGE cycle of a byte store.
        v = '{1'b1, 2'b00, 32'h0000_0050, 32'h0, 1, 1'b0, 32'h11AA_3344};
        run_vec(v, 101);
        we = 1'b1; size = 2'b10; addr = 32'h0000_0050; wdata = 32'h0000_00FF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("merge_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", {29'b0, busy, done, misaligned}, 32'b0);
        check("midreset_rdata", rdata, 32'b0);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midreset_no_done", dones, 0);
        v = '{1'b0, 2'b00, 32'h0000_0050, 32'h0, 1, 1'b0, 32'h0000_0000};
        run_vec(v, 102);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder at the far end of the CPU address/data bus. Serves the address the datapath's memory-address mux selects.
- Accepts one word, halfword or byte load/store request at a time against an internal word-wide synchronous RAM.
- Performs read-modify-write for sub-word stores and flags misaligned accesses back to the control unit, which raises the exception.
- Sits between the datapath memory port and the memory data register / control FSM.

Parameters:
ADDR_BITS, 8, word-index width; RAM depth = 2**ADDR_BITS 32-bit words

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
req  input  1  request strobe, sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (error)
addr  input  32  byte address
wdata  input  32  store data; sub-word data right-aligned in low bits
busy  output  1  high whenever state != IDLE
rdata  output  32  load result, zero-extended, registered
done  output  1  one-cycle completion pulse
misaligned  output  1  valid with done; 1 = request rejected

Behaviour:
- Reset (reset_n low at a rising edge):
  - State goes to IDLE; busy=0, done=0, misaligned=0, rdata=0.
  - Reset has priority over every other action, so no RAM write occurs on that edge.
  - RAM contents are not reset.
- Word index is addr[ADDR_BITS+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2**ADDR_BITS. Byte lane k is bits [8k+7:8k] (little-endian).
- Misalignment check, done at acceptance:
  - word with addr[1:0]!=0
  - half with addr[0]!=0
  - size=11
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - On req=1, latch addr/we/size/wdata.
  - Misaligned request: go to RESP with misaligned pending; no RAM access.
  - Otherwise go to ACCESS.
  - req=0: stay in IDLE.
- ACCESS, one cycle:
  - Word store: write wdata to RAM, go to RESP.
  - Any load or sub-word store: read RAM word into internal read register.
  - Load: go to RESP. Sub-word store: go to MERGE.
- MERGE, one cycle:
  - Write read-register word with the selected lane(s) replaced.
  - Byte store: lane addr[1:0] gets wdata[7:0].
  - Half store: lanes {2*addr[1]+1, 2*addr[1]} get wdata[15:0].
  - Go to RESP.
- RESP, one cycle:
  - done=1. misaligned = latched error flag.
  - rdata loaded, for loads only:
    - word: whole word
    - half: {16'b0, selected half}
    - byte: {24'b0, selected byte}
  - Stores and errors leave rdata unchanged.
  - Return to IDLE.
- rdata holds its value until the next successful load completes.
- Latency, counting from the accepting edge E0 (req high in IDLE); done is high during the cycle after edge:
  - error: E0
  - word store or any load: E0+1
  - sub-word store: E0+2
- Minimum spacing between accepted requests: error 2 cycles, load/word store 3 cycles, sub-word store 4 cycles.
- req asserted while busy=1 is ignored and not queued; the requester re-asserts after done. req in the RESP cycle is also ignored.
- Input changes after acceptance have no effect (all inputs latched).
- Reset mid-operation, including the MERGE cycle: operation aborted, no partial write, done not pulsed.
- Store followed by a load of the same word sees the new data (the write completes before the next acceptance).

Test Plan:
- Word store/load: store 0xDEADBEEF at addr 0x10, then load 0x10. Store: done 2 cycles after accept, misaligned=0. Load: rdata=0xDEADBEEF, done 2 cycles after accept.
- Byte RMW: word 0x11223344 at 0x20; store byte 0xAA at 0x22. Word load returns 0x11AA3344; byte load at 0x22 returns 0x000000AA; store done 3 cycles after accept.
- Halfword: store 0xBEEF at 0x32 over word 0 at 0x30. Word load returns 0xBEEF0000; half load at 0x30 returns 0x00000000.
- Misaligned: word load at 0x41, half store at 0x43, size=11 at 0x40. Each gives done 1 cycle after accept with misaligned=1; RAM word at 0x40 unchanged; rdata unchanged.
- Busy and wrap:
  - req held high through a load: exactly one done per accept; no extra transaction while busy.
  - With ADDR_BITS=8, store at 0x400 then load at 0x000 returns the stored value.
- Reset mid-op: byte store 0xFF to 0x50 (word previously 0x00000000), reset_n low in the MERGE cycle. Outputs cleared next edge, done never pulses, word load at 0x50 returns 0x00000000.
